// File: rtl/rv32_memory_lsu_if.sv
// Data-memory port of the memory stage: req/gnt request phase, rvalid response phase.
interface rv32_memory_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/rv32_memory_lsu.sv
// RV32 memory stage: drives loads/stores on the data-memory port, stalls while an access
// is outstanding, aligns/extends load data and registers results into the M/W register.
module rv32_memory_lsu #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reg_write_i,
  input  logic                   fp_reg_write_i,
  input  logic                   memory_write_i,
  input  logic [2:0]             result_source_i,
  input  logic [31:0]            instr_i,
  input  logic [31:0]            pc_next_i,
  input  logic [31:0]            alu_result_i,
  input  logic [31:0]            write_data_i,
  input  logic [31:0]            fpu_result_i,
  rv32_memory_lsu_if.master      dmem,
  output logic                   stall_m_o,
  output logic [31:0]            forwarded_res_m_o,
  output logic                   reg_write_o,
  output logic                   fp_reg_write_o,
  output logic [2:0]             result_source_o,
  output logic [31:0]            instr_o,
  output logic [31:0]            pc_next_o,
  output logic [31:0]            alu_result_o,
  output logic [31:0]            fpu_result_o,
  output logic [31:0]            load_data_o,
  output logic [1:0]             fault_o
);

  localparam logic [9:0] TMO_LAST = 10'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   byte_enable = 4'b0001 << a;
      2'b01:   byte_enable = a[1] ? 4'b1100 : 4'b0011;
      default: byte_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   store_lanes = {4{wd[7:0]}};
      2'b01:   store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~a[0];
      default: is_aligned = (a == 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rd);
    logic [31:0]        lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    lane = rd >> {a, 3'b000};
    b    = $signed(lane[7:0]);
    h    = $signed(a[1] ? rd[31:16] : rd[15:0]);
    case (f3)
      3'b000:  load_extend = 32'(b);
      3'b001:  load_extend = 32'(h);
      3'b100:  load_extend = {24'b0, lane[7:0]};
      3'b101:  load_extend = {16'b0, $unsigned(h)};
      default: load_extend = rd;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [9:0]  tmo_cnt_q;
  logic        mem_op, aligned, misaligned, tmo_hit;
  logic        req, stall, ld_done, tmo;
  logic        vld_p0;
  logic [1:0]  size;
  logic [1:0]  fault_p0;
  logic [31:0] load_data_p0;

  logic        reg_write_p1, fp_reg_write_p1;
  logic [2:0]  result_source_p1;
  logic [31:0] instr_p1, pc_next_p1, alu_result_p1, fpu_result_p1, load_data_p1;
  logic [1:0]  fault_p1;

  assign size       = instr_i[13:12];
  assign mem_op     = memory_write_i | (result_source_i == 3'b001);
  assign aligned    = is_aligned(size, alu_result_i[1:0]);
  assign misaligned = mem_op & ~aligned;
  // The cycle the counter reads BUS_TIMEOUT-1 is the BUS_TIMEOUT-th cycle spent in REQ/WAIT.
  assign tmo_hit    = (state_q != S_IDLE) && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    ld_done = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      S_IDLE, S_REQ: begin
        if (state_q == S_REQ && tmo_hit) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end else if (state_q == S_REQ || (mem_op && aligned)) begin
          req   = 1'b1;
          stall = 1'b1;
          if (dmem.gnt) begin
            if (memory_write_i) begin
              stall   = 1'b0;
              state_d = S_IDLE;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_WAIT: begin
        if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end else if (dmem.rvalid) begin
          ld_done = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset kills an in-flight request at once, without waiting for the clock.
  assign dmem.req   = req & ~rst_i;
  assign stall_m_o  = stall & ~rst_i;
  assign dmem.we    = memory_write_i;
  assign dmem.addr  = {alu_result_i[31:2], 2'b00};
  assign dmem.be    = byte_enable(size, alu_result_i[1:0]);
  assign dmem.wdata = store_lanes(size, write_data_i);

  assign forwarded_res_m_o = alu_result_i;

  assign vld_p0       = ~stall;
  assign fault_p0     = tmo ? 2'b10 : (misaligned ? 2'b01 : 2'b00);
  assign load_data_p0 = ld_done ? load_extend(instr_i[14:12], alu_result_i[1:0], dmem.rdata)
                                : 32'b0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= (state_q == S_IDLE) ? 10'd0 : tmo_cnt_q + 10'd1;
    end
  end

  // ---- M/W pipeline register (p1) ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_write_p1     <= 1'b0;
      fp_reg_write_p1  <= 1'b0;
      result_source_p1 <= '0;
      instr_p1         <= '0;
      pc_next_p1       <= '0;
      alu_result_p1    <= '0;
      fpu_result_p1    <= '0;
      load_data_p1     <= '0;
      fault_p1         <= '0;
    end else if (vld_p0) begin
      reg_write_p1     <= reg_write_i & (fault_p0 == 2'b00);
      fp_reg_write_p1  <= fp_reg_write_i & (fault_p0 == 2'b00);
      result_source_p1 <= result_source_i;
      instr_p1         <= instr_i;
      pc_next_p1       <= pc_next_i;
      alu_result_p1    <= alu_result_i;
      fpu_result_p1    <= fpu_result_i;
      load_data_p1     <= load_data_p0;
      fault_p1         <= fault_p0;
    end
  end

  assign reg_write_o     = reg_write_p1;
  assign fp_reg_write_o  = fp_reg_write_p1;
  assign result_source_o = result_source_p1;
  assign instr_o         = instr_p1;
  assign pc_next_o       = pc_next_p1;
  assign alu_result_o    = alu_result_p1;
  assign fpu_result_o    = fpu_result_p1;
  assign load_data_o     = load_data_p1;
  assign fault_o         = fault_p1;

endmodule

// File: tb/tb_rv32_memory_lsu.sv
// Randomized bench for rv32_memory_lsu against a transaction-level model of the memory stage.
module tb_rv32_memory_lsu;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_i, fp_reg_write_i, memory_write_i;
  logic [2:0]  result_source_i;
  logic [31:0] instr_i, pc_next_i, alu_result_i, write_data_i, fpu_result_i;
  logic        stall_m_o;
  logic [31:0] forwarded_res_m_o;
  logic        reg_write_o, fp_reg_write_o;
  logic [2:0]  result_source_o;
  logic [31:0] instr_o, pc_next_o, alu_result_o, fpu_result_o, load_data_o;
  logic [1:0]  fault_o;

  always #5 clk = ~clk;

  rv32_memory_lsu_if dmem_if ();

  rv32_memory_lsu #(.BUS_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .reg_write_i(reg_write_i), .fp_reg_write_i(fp_reg_write_i),
    .memory_write_i(memory_write_i), .result_source_i(result_source_i),
    .instr_i(instr_i), .pc_next_i(pc_next_i), .alu_result_i(alu_result_i),
    .write_data_i(write_data_i), .fpu_result_i(fpu_result_i),
    .dmem(dmem_if),
    .stall_m_o(stall_m_o), .forwarded_res_m_o(forwarded_res_m_o),
    .reg_write_o(reg_write_o), .fp_reg_write_o(fp_reg_write_o),
    .result_source_o(result_source_o), .instr_o(instr_o), .pc_next_o(pc_next_o),
    .alu_result_o(alu_result_o), .fpu_result_o(fpu_result_o),
    .load_data_o(load_data_o), .fault_o(fault_o)
  );

  typedef struct {
    logic        rw, fw, mw, nz;
    logic [2:0]  rs;
    logic [31:0] instr, pc, alu, wd, fpu, rdata;
    int          gd, rd;
  } op_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] p_alu;
  logic [1:0]  p_fault;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_aligned(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'b00) return 1'b1;
    if (size == 2'b01) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [31:0] ref_be(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'b00) return 32'd1 << (a % 4);
    if (size == 2'b01) return ((a % 4) >= 2) ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'b00) return (wd % 256) * 32'h0101_0101;
    if (size == 2'b01) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] bv, hv;
    bv = (w / (32'd1 << (8 * (a % 4)))) % 256;
    hv = ((a % 4) >= 2) ? (w / 65536) : (w % 65536);
    case (f3)
      3'd0:    return (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
      3'd1:    return (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
      3'd4:    return bv;
      3'd5:    return hv;
      default: return w;
    endcase
  endfunction

  function automatic op_t mk_op(input logic mw, input logic [2:0] rs, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] wd,
                                input logic [31:0] rdata, input int gd, input int rd);
    op_t o;
    o.rw = ~mw; o.fw = 1'b0; o.mw = mw; o.nz = 1'b0; o.rs = rs;
    o.instr = {17'h0, f3, 5'd10, mw ? 7'b0100011 : 7'b0000011};
    o.pc = 32'h0000_1004; o.alu = alu; o.wd = wd; o.fpu = 32'h3F80_0000;
    o.rdata = rdata; o.gd = gd; o.rd = rd;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  kind;
    logic [2:0] f3;
    kind = $urandom_range(0, 2);
    o.instr = $urandom; o.pc = $urandom; o.alu = $urandom; o.wd = $urandom;
    o.fpu = $urandom; o.rdata = $urandom;
    o.rw = 1'($urandom); o.fw = 1'($urandom); o.nz = 1'($urandom);
    o.rs = 3'($urandom_range(0, 7));
    if (o.rs == 3'b001) o.rs = 3'b000;
    o.mw = 1'b0;
    f3 = o.instr[14:12];
    if (kind == 1) begin
      o.rs = 3'b001;
      case ($urandom_range(0, 4))
        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
      endcase
    end else if (kind == 2) begin
      o.mw = 1'b1;
      f3 = 3'($urandom_range(0, 2));
    end
    o.instr[14:12] = f3;
    o.gd = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, 3);
    o.rd = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(1, 3);
    return o;
  endfunction

  // Applies one E/M instruction at a negedge and plays the memory side according to o.gd/o.rd.
  task automatic run_op(input op_t o);
    logic [2:0]  f3;
    bit          mem, ld, mis, go, tmo, req_e;
    int          k, e;
    logic [1:0]  f_e;
    f3  = o.instr[14:12];
    mem = o.mw || (o.rs == 3'b001);
    ld  = mem && !o.mw;
    mis = mem && !ref_aligned(f3[1:0], o.alu);
    go  = mem && !mis;
    k   = o.mw ? o.gd : o.gd + o.rd;
    tmo = go && (k >= TMO);
    e   = !go ? 0 : (tmo ? TMO : k);
    reg_write_i = o.rw; fp_reg_write_i = o.fw; memory_write_i = o.mw;
    result_source_i = o.rs; instr_i = o.instr; pc_next_i = o.pc;
    alu_result_i = o.alu; write_data_i = o.wd; fpu_result_i = o.fpu;
    dmem_if.rdata = o.rdata;
    for (int c = 0; c <= e; c++) begin
      dmem_if.gnt    = go && (c == o.gd) && (c < TMO);
      dmem_if.rvalid = (go && ld && (c == o.gd + o.rd) && (c < TMO)) || (o.nz && c <= o.gd);
      #1;
      req_e = go && (c <= o.gd) && (c < TMO);
      check_val("req", 32'(dmem_if.req), 32'(req_e));
      check_val("stall", 32'(stall_m_o), 32'(go && (c < e)));
      if (c == 0) check_val("fwd", forwarded_res_m_o, o.alu);
      if (req_e) begin
        check_val("be", 32'(dmem_if.be), ref_be(f3[1:0], o.alu));
        check_val("wdata", dmem_if.wdata, ref_wdata(f3[1:0], o.wd));
        check_val("addr", dmem_if.addr, o.alu & 32'hFFFF_FFFC);
        check_val("we", 32'(dmem_if.we), 32'(o.mw));
      end
      if (c > 0) begin
        check_val("hold_alu", alu_result_o, p_alu);
        check_val("hold_fault", 32'(fault_o), 32'(p_fault));
      end
      @(posedge clk);
      @(negedge clk);
    end
    dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0;
    f_e = tmo ? 2'b10 : (mis ? 2'b01 : 2'b00);
    #1;
    check_val("fault", 32'(fault_o), 32'(f_e));
    check_val("reg_write", 32'(reg_write_o), 32'(o.rw && f_e == 2'b00));
    check_val("fp_reg_write", 32'(fp_reg_write_o), 32'(o.fw && f_e == 2'b00));
    check_val("result_source", 32'(result_source_o), 32'(o.rs));
    check_val("instr", instr_o, o.instr);
    check_val("pc_next", pc_next_o, o.pc);
    check_val("alu_result", alu_result_o, o.alu);
    check_val("fpu_result", fpu_result_o, o.fpu);
    check_val("load_data", load_data_o,
              (go && ld && !tmo) ? ref_load(f3, o.alu, o.rdata) : 32'h0);
    p_alu = o.alu; p_fault = f_e;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    reg_write_i = 0; fp_reg_write_i = 0; memory_write_i = 0; result_source_i = 0;
    instr_i = 0; pc_next_i = 0; alu_result_i = 0; write_data_i = 0; fpu_result_i = 0;
    dmem_if.gnt = 0; dmem_if.rvalid = 0; dmem_if.rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_req", 32'(dmem_if.req), 32'h0);
    check_val("rst_stall", 32'(stall_m_o), 32'h0);
    check_val("rst_reg_write", 32'(reg_write_o), 32'h0);
    check_val("rst_fault", 32'(fault_o), 32'h0);
    check_val("rst_alu", alu_result_o, 32'h0);
    check_val("rst_load", load_data_o, 32'h0);
    rst = 1'b0;
    p_alu = 0; p_fault = 0;

    run_op(mk_op(1'b0, 3'b001, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1));
    check_val("lw_spec", load_data_o, 32'hDEAD_BEEF);
    run_op(mk_op(1'b0, 3'b001, 3'd0, 32'h103, 32'h0, 32'h8012_3456, 1, 2));
    check_val("lb_spec", load_data_o, 32'hFFFF_FF80);
    run_op(mk_op(1'b0, 3'b001, 3'd4, 32'h103, 32'h0, 32'h8012_3456, 0, 1));
    check_val("lbu_spec", load_data_o, 32'h0000_0080);
    run_op(mk_op(1'b1, 3'b000, 3'd1, 32'h102, 32'h1234_ABCD, 32'h0, 3, 1));
    run_op(mk_op(1'b0, 3'b001, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1));
    check_val("misaligned_spec", 32'(fault_o), 32'h1);
    run_op(mk_op(1'b0, 3'b001, 3'd2, 32'h100, 32'h0, 32'h0, 0, 9));
    check_val("timeout_spec", 32'(fault_o), 32'h2);
    run_op(mk_op(1'b1, 3'b000, 3'd0, 32'h201, 32'h0000_00A5, 32'h0, 0, 1));
    run_op(mk_op(1'b0, 3'b001, 3'd5, 32'h302, 32'h0, 32'h8001_7FFF, 2, 1));
    run_op(mk_op(1'b0, 3'b001, 3'd1, 32'h303, 32'h0, 32'h0, 0, 1));

    // Reset while the load waits for its response.
    reg_write_i = 1; fp_reg_write_i = 0; memory_write_i = 0; result_source_i = 3'b001;
    instr_i = 32'h0000_2503; alu_result_i = 32'h200; dmem_if.gnt = 1'b1;
    #1;
    check_val("rw_req", 32'(dmem_if.req), 32'h1);
    @(posedge clk); @(negedge clk);
    dmem_if.gnt = 1'b0;
    #1;
    check_val("rw_wait_stall", 32'(stall_m_o), 32'h1);
    rst = 1'b1;
    #1;
    check_val("rw_rst_req", 32'(dmem_if.req), 32'h0);
    check_val("rw_rst_stall", 32'(stall_m_o), 32'h0);
    check_val("rw_rst_alu", alu_result_o, 32'h0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    result_source_i = 3'b000; alu_result_i = 32'h55; instr_i = 32'h0000_0033;
    dmem_if.rvalid = 1'b1; dmem_if.rdata = 32'hCAFE_F00D;
    #1;
    check_val("late_rvalid_stall", 32'(stall_m_o), 32'h0);
    check_val("late_rvalid_req", 32'(dmem_if.req), 32'h0);
    @(posedge clk); @(negedge clk);
    dmem_if.rvalid = 1'b0;
    check_val("late_rvalid_alu", alu_result_o, 32'h55);
    check_val("late_rvalid_load", load_data_o, 32'h0);
    check_val("late_rvalid_fault", 32'(fault_o), 32'h0);
    p_alu = 32'h55; p_fault = 2'b00;
    run_op(mk_op(1'b0, 3'b001, 3'd2, 32'h204, 32'h0, 32'h1357_9BDF, 1, 1));

    for (int i = 0; i < 300; i++) run_op(rand_op());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
